// File: rtl/mem_wb_stage.sv
// Back half of the 16-bit pipeline: EX/MEM register, data memory, MEM/WB register
// and write-back mux. All state changes on the falling edge of clk.
module mem_wb_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic [1:0]  ex_wr,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_memwrite,
  output logic [15:0] exmem_alu_out,
  output logic [1:0]  exmem_wr,
  output logic        exmem_regwrite,
  output logic [15:0] wb_wd,
  output logic [1:0]  wb_wr,
  output logic        wb_regwrite,
  output logic        misalign
);

  logic [15:0] exmem_alu_out_q, exmem_alu_out_d;
  logic [15:0] exmem_store_data_q, exmem_store_data_d;
  logic [1:0]  exmem_wr_q, exmem_wr_d;
  logic        exmem_regwrite_q, exmem_regwrite_d;
  logic        exmem_memtoreg_q, exmem_memtoreg_d;
  logic        exmem_memwrite_q, exmem_memwrite_d;
  logic [15:0] wb_wd_q, wb_wd_d;
  logic [1:0]  wb_wr_q, wb_wr_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        misalign_q, misalign_d;

  logic [15:0] mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [15:0] rdata;
  logic          odd_access;
  logic          store_en;

  always_comb begin
    idx        = exmem_alu_out_q[AW:1];
    rdata      = mem_q[idx];
    odd_access = exmem_alu_out_q[0] & (exmem_memwrite_q | exmem_memtoreg_q);
    store_en   = rst_n & exmem_memwrite_q & ~exmem_alu_out_q[0];

    exmem_alu_out_d    = ex_alu_out;
    exmem_store_data_d = ex_store_data;
    exmem_wr_d         = ex_wr;
    exmem_regwrite_d   = ex_regwrite & (ex_wr != 2'b00);
    exmem_memtoreg_d   = ex_memtoreg;
    exmem_memwrite_d   = ex_memwrite;

    // rdata is the pre-write value, so a same-edge store does not alter this load
    wb_wd_d       = exmem_memtoreg_q ? rdata : exmem_alu_out_q;
    wb_wr_d       = exmem_wr_q;
    wb_regwrite_d = exmem_regwrite_q;
    misalign_d    = misalign_q | odd_access;
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      exmem_alu_out_q    <= '0;
      exmem_store_data_q <= '0;
      exmem_wr_q         <= '0;
      exmem_regwrite_q   <= 1'b0;
      exmem_memtoreg_q   <= 1'b0;
      exmem_memwrite_q   <= 1'b0;
      wb_wd_q            <= '0;
      wb_wr_q            <= '0;
      wb_regwrite_q      <= 1'b0;
      misalign_q         <= 1'b0;
    end else begin
      exmem_alu_out_q    <= exmem_alu_out_d;
      exmem_store_data_q <= exmem_store_data_d;
      exmem_wr_q         <= exmem_wr_d;
      exmem_regwrite_q   <= exmem_regwrite_d;
      exmem_memtoreg_q   <= exmem_memtoreg_d;
      exmem_memwrite_q   <= exmem_memwrite_d;
      wb_wd_q            <= wb_wd_d;
      wb_wr_q            <= wb_wr_d;
      wb_regwrite_q      <= wb_regwrite_d;
      misalign_q         <= misalign_d;
    end
  end

  // Data memory contents survive reset
  always_ff @(negedge clk) begin
    if (store_en)
      mem_q[idx] <= exmem_store_data_q;
  end

  assign exmem_alu_out  = exmem_alu_out_q;
  assign exmem_wr       = exmem_wr_q;
  assign exmem_regwrite = exmem_regwrite_q;
  assign wb_wd          = wb_wd_q;
  assign wb_wr          = wb_wr_q;
  assign wb_regwrite    = wb_regwrite_q;
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, pass-through, store/load, wrap,
// misaligned access and $0 suppression.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ex_alu_out, ex_store_data;
  logic [1:0]  ex_wr;
  logic        ex_regwrite, ex_memtoreg, ex_memwrite;
  logic [15:0] exmem_alu_out, wb_wd;
  logic [1:0]  exmem_wr, wb_wr;
  logic        exmem_regwrite, wb_regwrite, misalign;

  int tests = 0;
  int fails = 0;

  mem_wb_stage #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_wr(ex_wr),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .exmem_alu_out(exmem_alu_out), .exmem_wr(exmem_wr), .exmem_regwrite(exmem_regwrite),
    .wb_wd(wb_wd), .wb_wr(wb_wr), .wb_regwrite(wb_regwrite), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] alu, input logic [15:0] sd, input logic [1:0] wr,
                       input logic rw, input logic m2r, input logic mw);
    ex_alu_out    = alu;
    ex_store_data = sd;
    ex_wr         = wr;
    ex_regwrite   = rw;
    ex_memtoreg   = m2r;
    ex_memwrite   = mw;
  endtask

  task automatic nop();
    drive(16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one falling edge and settle
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held 2 edges with a store/regwrite presented
    rst_n = 1'b0;
    drive(16'h0020, 16'h5555, 2'd2, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    chk("rst_exmem_alu", exmem_alu_out, 16'h0000);
    chk("rst_exmem_wr", {14'b0, exmem_wr}, 16'h0000);
    chk("rst_exmem_rw", {15'b0, exmem_regwrite}, 16'h0000);
    chk("rst_wb_wd", wb_wd, 16'h0000);
    chk("rst_wb_wr", {14'b0, wb_wr}, 16'h0000);
    chk("rst_wb_rw", {15'b0, wb_regwrite}, 16'h0000);
    chk("rst_misalign", {15'b0, misalign}, 16'h0000);

    // Seed word 0x20, then reset with a pending store to it
    rst_n = 1'b1;
    drive(16'h0020, 16'h00AA, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'h0020, 16'h5555, 2'd2, 1'b1, 1'b0, 1'b1);
    tick();              // seed store lands; 0x5555 store enters EX/MEM
    rst_n = 1'b0;
    tick(); tick();      // EX/MEM store discarded by reset
    rst_n = 1'b1;
    drive(16'h0020, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); nop(); tick();
    chk("rst_mem_kept", wb_wd, 16'h00AA);
    chk("rst_mem_kept_wr", {14'b0, wb_wr}, 16'h0001);

    // ALU pass-through
    drive(16'd22, 16'h0000, 2'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pass_exmem_wr", {14'b0, exmem_wr}, 16'h0003);
    chk("pass_exmem_alu", exmem_alu_out, 16'd22);
    chk("pass_exmem_rw", {15'b0, exmem_regwrite}, 16'h0001);
    nop(); tick();
    chk("pass_wb_wd", wb_wd, 16'd22);
    chk("pass_wb_wr", {14'b0, wb_wr}, 16'h0003);
    chk("pass_wb_rw", {15'b0, wb_regwrite}, 16'h0001);

    // Store then immediately load same word
    drive(16'h0010, 16'hBEEF, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'h0010, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("sw_bubble_rw", {15'b0, wb_regwrite}, 16'h0000);
    nop(); tick();
    chk("swlw_wd", wb_wd, 16'hBEEF);
    chk("swlw_wr", {14'b0, wb_wr}, 16'h0002);
    chk("swlw_rw", {15'b0, wb_regwrite}, 16'h0001);

    // Address wrap: 0x0200 aliases word 0
    drive(16'h0200, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'h0000, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0);
    tick(); nop(); tick();
    chk("wrap_wd", wb_wd, 16'h1234);
    chk("wrap_no_misalign", {15'b0, misalign}, 16'h0000);

    // $0 suppression
    drive(16'd15, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("r0_exmem_rw", {15'b0, exmem_regwrite}, 16'h0000);
    nop(); tick();
    chk("r0_wb_rw", {15'b0, wb_regwrite}, 16'h0000);
    chk("r0_wb_wd", wb_wd, 16'd15);

    // MemWrite and RegWrite together
    drive(16'h0030, 16'h7777, 2'd3, 1'b1, 1'b0, 1'b1);
    tick();
    drive(16'h0030, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("swrw_wd", wb_wd, 16'h0030);
    chk("swrw_rw", {15'b0, wb_regwrite}, 16'h0001);
    nop(); tick();
    chk("swrw_load", wb_wd, 16'h7777);

    // Misaligned store over a word holding 0x00AA
    drive(16'h0010, 16'h00AA, 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); nop(); tick();
    chk("pre_misalign", {15'b0, misalign}, 16'h0000);
    drive(16'h0011, 16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); nop(); tick();
    chk("misalign_set", {15'b0, misalign}, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("misalign_sticky", {15'b0, misalign}, 16'h0001);
    end
    drive(16'h0010, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b0);
    tick(); nop(); tick();
    chk("misalign_word_kept", wb_wd, 16'h00AA);
    drive(16'h0011, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b0);
    tick(); nop(); tick();
    chk("misalign_load", wb_wd, 16'h00AA);
    rst_n = 1'b0;
    tick();
    chk("misalign_cleared", {15'b0, misalign}, 16'h0000);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
